// File: rtl/barker_sync_pkg.sv
// Shared types for the Barker frame-sync controller: FSM states, window flags
// and the beat-counter width helper.
package barker_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Flags describe the beat currently presented, i.e. d = cnt + 1.
    typedef struct packed {
        logic in_window;
        logic early;
        logic timeout;
    } win_flags_t;

    function automatic int cnt_width(input int frame_len, input int tol);
        return $clog2(frame_len + tol + 1);
    endfunction

endpackage

// File: rtl/sync_window_counter.sv
// Beat counter measuring distance from the last anchor peak; reports whether
// the current beat falls early, inside the acceptance window, or at timeout.
module sync_window_counter
    import barker_sync_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int TOL       = 1,
    parameter int CW        = cnt_width(FRAME_LEN, TOL)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       load_tol,
    output win_flags_t flags
);

    localparam logic [CW-1:0] WIN_LO = CW'(FRAME_LEN - TOL);
    localparam logic [CW-1:0] WIN_HI = CW'(FRAME_LEN + TOL);
    localparam logic [CW-1:0] TOL_V  = CW'(TOL);

    logic [CW-1:0] cnt;
    logic [CW-1:0] d;

    assign d = cnt + CW'(1);

    // The FSM always clears or reloads at d == WIN_HI, so cnt stays below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load_tol) begin
            cnt <= TOL_V;
        end else if (en) begin
            cnt <= d;
        end
    end

    assign flags.in_window = (d >= WIN_LO) && (d <= WIN_HI);
    assign flags.early     = (d < WIN_LO);
    assign flags.timeout   = (d == WIN_HI);

endmodule

// File: rtl/barker_sync_controller.sv
// Frame-sync FSM: acquires lock on correctly spaced correlator peaks,
// flywheels through missed peaks and reports loss of lock.
module barker_sync_controller
    import barker_sync_pkg::*;
#(
    parameter int FRAME_LEN   = 64,
    parameter int TOL         = 1,
    parameter int CONFIRM_CNT = 3,
    parameter int MISS_MAX    = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic s_tvalid,
    input  logic s_tuser,
    output logic s_tready,
    output logic o_frame_start,
    output logic o_coast,
    output logic o_locked,
    output logic o_lost
);

    localparam int CW = cnt_width(FRAME_LEN, TOL);
    localparam int HW = $clog2(CONFIRM_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [HW-1:0] HITS_LAST = HW'(CONFIRM_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

    sync_state_t   state;
    logic [HW-1:0] hits;
    logic [MW-1:0] misses;
    win_flags_t    flags;
    logic          beat;
    logic          cnt_clr;
    logic          cnt_load;

    assign beat = s_tvalid && s_tready;

    sync_window_counter #(
        .FRAME_LEN (FRAME_LEN),
        .TOL       (TOL),
        .CW        (CW)
    ) u_win (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .en       (beat),
        .clr      (cnt_clr),
        .load_tol (cnt_load),
        .flags    (flags)
    );

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        if (i_clear) begin
            cnt_clr = 1'b1;
        end else if (beat) begin
            case (state)
                SEARCH: cnt_clr = 1'b1;
                VERIFY: cnt_clr = s_tuser || flags.timeout;
                LOCKED: begin
                    if (s_tuser && flags.in_window) begin
                        cnt_clr = 1'b1;
                    end else if (flags.timeout) begin
                        // Flywheel re-anchors at the nominal peak position.
                        cnt_clr  = (misses == MISS_LAST);
                        cnt_load = (misses != MISS_LAST);
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= SEARCH;
            hits          <= '0;
            misses        <= '0;
            s_tready      <= 1'b0;
            o_frame_start <= 1'b0;
            o_coast       <= 1'b0;
            o_locked      <= 1'b0;
            o_lost        <= 1'b0;
        end else begin
            s_tready      <= 1'b1;
            o_frame_start <= 1'b0;
            o_coast       <= 1'b0;
            o_lost        <= 1'b0;
            if (i_clear) begin
                o_lost   <= (state == LOCKED);
                state    <= SEARCH;
                hits     <= '0;
                misses   <= '0;
                o_locked <= 1'b0;
            end else if (beat) begin
                case (state)
                    SEARCH: begin
                        if (s_tuser) begin
                            state <= VERIFY;
                            hits  <= HW'(1);
                        end
                    end
                    VERIFY: begin
                        if (s_tuser && flags.in_window) begin
                            if (hits == HITS_LAST) begin
                                state         <= LOCKED;
                                hits          <= '0;
                                misses        <= '0;
                                o_frame_start <= 1'b1;
                                o_locked      <= 1'b1;
                            end else begin
                                hits <= hits + HW'(1);
                            end
                        end else if (s_tuser && flags.early) begin
                            hits <= HW'(1);
                        end else if (flags.timeout) begin
                            state <= SEARCH;
                            hits  <= '0;
                        end
                    end
                    LOCKED: begin
                        // Early peaks while locked are treated as noise.
                        if (s_tuser && flags.in_window) begin
                            misses        <= '0;
                            o_frame_start <= 1'b1;
                        end else if (flags.timeout) begin
                            if (misses == MISS_LAST) begin
                                state    <= SEARCH;
                                misses   <= '0;
                                o_lost   <= 1'b1;
                                o_locked <= 1'b0;
                            end else begin
                                misses        <= misses + MW'(1);
                                o_frame_start <= 1'b1;
                                o_coast       <= 1'b1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barker_sync_controller.sv
// Scoreboard bench: a beat-index reference model predicts every cycle's outputs;
// a negedge monitor pops and compares them independently of the driver.
module tb_barker_sync_controller;

    localparam int FL    = 16;
    localparam int TOL   = 1;
    localparam int CONF  = 3;
    localparam int MMAX  = 2;
    localparam int M_SRCH = 0;
    localparam int M_VER  = 1;
    localparam int M_LOCK = 2;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    logic i_clear = 1'b0;
    logic s_tvalid = 1'b0;
    logic s_tuser = 1'b0;
    logic s_tready;
    logic o_frame_start;
    logic o_coast;
    logic o_locked;
    logic o_lost;

    always #5 i_clk = ~i_clk;

    barker_sync_controller #(
        .FRAME_LEN   (FL),
        .TOL         (TOL),
        .CONFIRM_CNT (CONF),
        .MISS_MAX    (MMAX)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (i_clear),
        .s_tvalid      (s_tvalid),
        .s_tuser       (s_tuser),
        .s_tready      (s_tready),
        .o_frame_start (o_frame_start),
        .o_coast       (o_coast),
        .o_locked      (o_locked),
        .o_lost        (o_lost)
    );

    typedef struct {
        bit fs;
        bit coast;
        bit locked;
        bit lost;
        bit ready;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: absolute beat index and the index of the last anchor.
    int m_mode = M_SRCH;
    int m_bidx = 0;
    int m_anchor = 0;
    int m_hits = 0;
    int m_miss = 0;
    bit m_locked = 0;
    bit m_ready = 0;

    function automatic void chk(string name, logic act, bit req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge i_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_start", o_frame_start, e.fs);
            chk("coast", o_coast, e.coast);
            chk("locked", o_locked, e.locked);
            chk("lost", o_lost, e.lost);
            chk("tready", s_tready, e.ready);
        end
    end

    task automatic model_step(input bit v, input bit p, input bit c, output exp_t e);
        int d;
        e.fs = 0;
        e.coast = 0;
        e.lost = 0;
        if (c) begin
            e.lost = (m_mode == M_LOCK);
            m_mode = M_SRCH;
            m_hits = 0;
            m_miss = 0;
            m_locked = 0;
        end else if (v && m_ready) begin
            m_bidx++;
            d = m_bidx - m_anchor;
            case (m_mode)
                M_SRCH: if (p) begin
                    m_anchor = m_bidx;
                    m_hits = 1;
                    m_mode = M_VER;
                end
                M_VER: begin
                    if (p && d >= FL - TOL) begin
                        m_anchor = m_bidx;
                        m_hits++;
                        if (m_hits == CONF) begin
                            m_mode = M_LOCK;
                            m_locked = 1;
                            m_miss = 0;
                            e.fs = 1;
                        end
                    end else if (p) begin
                        m_anchor = m_bidx;
                        m_hits = 1;
                    end else if (d == FL + TOL) begin
                        m_mode = M_SRCH;
                        m_hits = 0;
                    end
                end
                default: begin
                    if (p && d >= FL - TOL) begin
                        m_anchor = m_bidx;
                        m_miss = 0;
                        e.fs = 1;
                    end else if (d == FL + TOL) begin
                        m_miss++;
                        if (m_miss == MMAX) begin
                            m_mode = M_SRCH;
                            m_miss = 0;
                            m_locked = 0;
                            e.lost = 1;
                        end else begin
                            m_anchor = m_bidx - TOL;
                            e.fs = 1;
                            e.coast = 1;
                        end
                    end
                end
            endcase
        end
        m_ready = 1;
        e.locked = m_locked;
        e.ready = m_ready;
    endtask

    task automatic step(input bit v, input bit p, input bit c);
        exp_t e;
        s_tvalid = v;
        s_tuser = p;
        i_clear = c;
        @(posedge i_clk);
        #1;
        model_step(v, p, c, e);
        sb.push_back(e);
    endtask

    task automatic beats(input int n, input int pk[$], input bit gapped);
        for (int b = 0; b < n; b++) begin
            bit p;
            p = 0;
            foreach (pk[k]) if (pk[k] == b) p = 1;
            if (gapped) step(0, 0, 0);
            step(1, p, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_rst_n = 0;
        s_tvalid = 0;
        s_tuser = 0;
        i_clear = 0;
        #1;
        chk("rst_frame_start", o_frame_start, 0);
        chk("rst_coast", o_coast, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_lost", o_lost, 0);
        chk("rst_tready", s_tready, 0);
        m_mode = M_SRCH;
        m_hits = 0;
        m_miss = 0;
        m_locked = 0;
        m_ready = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst_n = 1;
        step(0, 0, 0);
    endtask

    initial begin
        int pk[$];
        int ivals[10];
        int gap;
        ivals = '{13, 15, 16, 16, 16, 16, 17, 18, 32, 48};

        // Acquire, then jitter at d=15/17, then flywheel and loss.
        do_reset();
        pk = '{5, 21, 37};
        beats(40, pk, 0);
        pk = '{12, 29};
        beats(70, pk, 0);

        // VERIFY re-anchor: the peak at 10 restarts the confirmation run.
        do_reset();
        pk = '{0, 10, 26, 42};
        beats(50, pk, 0);

        // Gapped acquire, then clear coinciding with an in-window peak.
        do_reset();
        pk = '{5, 21, 37};
        beats(45, pk, 1);
        pk = {};
        beats(8, pk, 0);
        step(1, 1, 1);
        pk = '{15};
        beats(40, pk, 0);

        // Reset while locked.
        do_reset();
        pk = '{5, 21, 37};
        beats(45, pk, 0);
        do_reset();

        // Randomised peak streams with jitter, misses, spurious peaks and clears.
        gap = 16;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit p;
            bit c;
            v = ($urandom_range(0, 3) != 0);
            p = 0;
            c = ($urandom_range(0, 399) == 0);
            if (v) begin
                gap--;
                if (gap <= 0) begin
                    p = 1;
                    gap = ivals[$urandom_range(0, 9)];
                end else if ($urandom_range(0, 49) == 0) begin
                    p = 1;
                end
            end
            step(v, p, c);
        end
        step(0, 0, 0);

        @(negedge i_clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barker_sync_controller.md
# barker_sync_controller

Frame-synchronisation controller that sits downstream of the Barker correlator core and consumes its 1-bit per-sample peak flag. It counts accepted sample beats between peaks and confirms lock after a run of correctly spaced peaks. While locked it flywheels through missed peaks and declares loss after a configured number of consecutive misses. It emits a frame-start strobe and lock status to the deframer, and drives the correlator's output-side ready.

## Interface
- FRAME_LEN, 64: nominal beats between Barker peaks; ≥ 8.
- TOL, 1: accepted ±beat deviation; constraint 2·TOL < FRAME_LEN.
- CONFIRM_CNT, 3: peaks in window needed to lock, including the anchor; ≥ 2.
- MISS_MAX, 2: consecutive misses that drop lock; ≥ 1.
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous forced return to SEARCH.
- s_tvalid  in  1  correlator output beat valid.
- s_tuser  in  1  peak flag on the beat.
- s_tready  out  1  beat accept.
- o_frame_start  out  1  one-cycle frame boundary strobe.
- o_coast  out  1  qualifies o_frame_start as flywheel-generated.
- o_locked  out  1  lock status level.
- o_lost  out  1  one-cycle loss-of-lock strobe.

## Operation
- Beat = s_tvalid && s_tready. Non-beat cycles freeze all state.
- cnt = beats since anchor. d = cnt+1 on the current beat. Window = FRAME_LEN−TOL ≤ d ≤ FRAME_LEN+TOL.
- Counter width is $clog2(FRAME_LEN+TOL+1). cnt never exceeds FRAME_LEN+TOL.
- SEARCH: peak beat → cnt=0, hits=1, go to VERIFY.
- VERIFY, peak in window: cnt=0, hits++. If hits reaches CONFIRM_CNT → LOCKED, misses=0, o_frame_start=1, o_coast=0.
- VERIFY, peak before window: re-anchor with cnt=0, hits=1.
- VERIFY, no peak with d=FRAME_LEN+TOL: → SEARCH, hits=0.
- LOCKED, peak in window: cnt=0, misses=0, o_frame_start=1, o_coast=0.
- LOCKED, peak before window: ignored; cnt keeps counting.
- LOCKED, no peak with d=FRAME_LEN+TOL: misses++.
  - misses still < MISS_MAX: o_frame_start=1, o_coast=1, and cnt=TOL (re-anchor at nominal position).
  - misses reaches MISS_MAX: → SEARCH, o_lost=1, o_locked=0, no frame strobe.
- A peak at exactly d=FRAME_LEN+TOL is a hit. The peak check takes priority over timeout.
- i_clear beats everything, including a same-cycle peak: → SEARCH, cnt/hits/misses=0. If LOCKED, o_lost=1.
- s_tready=1 in every state after reset. The block never back-pressures.

## Timing
- All outputs registered. Strobes assert on the clock edge after the deciding beat, for exactly one cycle.
- o_locked changes on the same edge as the deciding strobe.
- Reset (async assert, sync release): state SEARCH, counters 0, o_frame_start/o_coast/o_locked/o_lost=0, s_tready=0.
- s_tready rises on the first edge after release.
- Reset mid-LOCKED clears everything immediately. No o_lost is emitted.
- o_coast is 0 whenever o_frame_start is 0.

## Structure
- Package barker_sync_pkg: state enum sync_state_t {SEARCH, VERIFY, LOCKED}, and a function computing counter width from FRAME_LEN and TOL.
- Sub-module sync_window_counter:
  - beat counter with clear/load-TOL controls;
  - outputs in_window, early and timeout flags.
- The top FSM holds hits/misses and the output registers.

## Test plan
All scenarios use FRAME_LEN=16, TOL=1, CONFIRM_CNT=3, MISS_MAX=2, continuous s_tvalid unless stated.
- Acquire: peaks on beats 5, 21, 37 → o_locked rises and o_frame_start pulses (o_coast=0) one cycle after beat 37. No strobe earlier.
- Jitter tolerance: after lock, peaks at d=15 then d=17 → two strobes, o_coast=0, o_locked stays 1.
- Flywheel and loss: after lock, no further peaks.
  - At d=17: o_frame_start=1 with o_coast=1.
  - 16 beats later (d reaches 17 again): o_lost pulses and o_locked falls.
- VERIFY re-anchor: peaks at beats 0, 10, 26, 42 → peak at 10 re-anchors. Lock after beat 42, not beat 26.
- Gapped input: scenario 1 with s_tvalid low every other cycle → identical beat-relative results, and strobes remain single-cycle.
- Clear and reset:
  - i_clear coincident with an in-window peak while LOCKED → o_lost pulse, SEARCH, next peak only anchors.
  - i_rst_n low mid-LOCKED → all outputs 0 asynchronously, s_tready low until one edge after release.
